// File: rtl/handshake_tx.sv
// Source side of a 4-phase req/ack handshake: takes a word over valid/ready,
// holds it on data_out while req_out is high, and waits on a synchronized ack.
module handshake_tx #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             send_valid,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [CNT_W-1:0]       counter;
  logic                   ack_s;

  // ack_in comes from an unrelated clock domain, so only its synchronized copy is used
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign send_ready = (state == IDLE) && !ack_s && Reset;
  assign busy       = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      req_out     <= 1'b0;
      data_out    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      counter     <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (send_valid && send_ready) begin
            data_out <= send_data;
            req_out  <= 1'b1;
            state    <= REQ;
            counter  <= '0;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_out <= 1'b0;
            done    <= 1'b1;
            state   <= REL;
          end else if ((TIMEOUT != 0) && (counter == CNT_LAST)) begin
            req_out     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= REL;
          end else if (counter != {CNT_W{1'b1}}) begin
            counter <= counter + CNT_W'(1);
          end
        end
        REL: begin
          // the far side must drop ack before another word may start
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_tx.sv
// Bench for handshake_tx: scoreboard of accepted words checked by a monitor
// against a far-side model that echoes req with a chosen delay or stays silent.
module tb_handshake_tx;

  localparam int WIDTH = 10;
  localparam int SYNC  = 2;
  localparam int TMO   = 8;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             send_valid = 1'b0;
  logic [WIDTH-1:0] send_data = '0;
  logic             send_ready;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic             ack_in;
  logic             busy;
  logic             done;
  logic             timeout_err;

  logic       far_echo = 1'b0;
  logic [1:0] echo_lat = 2'd0;
  logic       ack_level = 1'b0;
  logic [3:0] req_pipe = '0;
  logic [3:0] echo_tap;

  int cycle = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int ready_due = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               is_timeout;
    int               accept_cycle;
    int               outcome_lat;
    int               ready_lat;
  } exp_t;

  exp_t sbq[$];

  handshake_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .send_valid(send_valid),
    .send_data(send_data),
    .send_ready(send_ready),
    .req_out(req_out),
    .data_out(data_out),
    .ack_in(ack_in),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cycle    <= cycle + 1;
    req_pipe <= {req_pipe[2:0], req_out};
  end

  // far side: either echoes req_out after echo_lat cycles or holds a fixed level
  assign echo_tap = {req_pipe[2:0], req_out};
  always_comb begin
    ack_in = ack_level;
    if (far_echo) ack_in = echo_tap[echo_lat];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // monitor: compares DUT behaviour with the head of the scoreboard each cycle
  always @(negedge Clk) begin
    if (Reset) begin
      if (sbq.size() > 0 && cycle >= sbq[0].accept_cycle) begin
        checkOutput("req_level", {31'd0, req_out},
                    {31'd0, (cycle < sbq[0].accept_cycle + sbq[0].outcome_lat)});
        checkOutput("data_hold", {22'd0, data_out}, {22'd0, sbq[0].data});
      end
      if (done || timeout_err) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_pulse", {30'd0, done, timeout_err}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("outcome_kind", {30'd0, done, timeout_err},
                      e.is_timeout ? 32'd1 : 32'd2);
          checkOutput("outcome_latency", cycle - e.accept_cycle, e.outcome_lat);
          checkOutput("data_at_outcome", {22'd0, data_out}, {22'd0, e.data});
          ready_due = e.accept_cycle + e.ready_lat;
        end
      end else if (ready_due != 0) begin
        if (cycle < ready_due) begin
          checkOutput("ready_low_while_busy", {31'd0, send_ready}, 32'd0);
          checkOutput("busy_high", {31'd0, busy}, 32'd1);
        end else begin
          checkOutput("ready_return", {31'd0, send_ready}, 32'd1);
          checkOutput("busy_clear", {31'd0, busy}, 32'd0);
          ready_due = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit echo, input int lat);
    int  c;
    bit  got;
    bit  finished;
    exp_t e;
    @(negedge Clk);
    far_echo   = echo;
    echo_lat   = 2'(lat);
    ack_level  = 1'b0;
    send_valid = 1'b1;
    send_data  = d;
    got = 1'b0;
    c = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (i != 0) @(negedge Clk);
      c   = cycle;
      got = send_ready;
      @(posedge Clk);
    end
    if (!got) begin
      checkOutput("accept_wait", 32'd0, 32'd1);
      send_valid = 1'b0;
      return;
    end
    e.data         = d;
    e.is_timeout   = !echo;
    e.accept_cycle = c + 1;
    e.outcome_lat  = echo ? (lat + SYNC + 1) : TMO;
    e.ready_lat    = echo ? (2 * lat + 2 * SYNC + 2) : (TMO + 1);
    sbq.push_back(e);
    finished = 1'b0;
    for (int i = 0; i < 100 && !finished; i++) begin
      @(negedge Clk);
      if (send_ready) begin
        send_valid = 1'b0;
        finished   = 1'b1;
      end else begin
        send_valid = 1'($urandom_range(0, 1));
        send_data  = ($urandom_range(0, 1) != 0) ? 10'h155 : WIDTH'($urandom);
      end
    end
    if (!finished) checkOutput("handshake_complete", 32'd0, 32'd1);
    send_valid = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] w;

    // reset state with ack_in low
    repeat (3) @(negedge Clk);
    checkOutput("rst_req_out", {31'd0, req_out}, 32'd0);
    checkOutput("rst_data_out", {22'd0, data_out}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready_forced_low", {31'd0, send_ready}, 32'd0);
    checkOutput("rst_pulses", {30'd0, done, timeout_err}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("ready_after_release", {31'd0, send_ready}, 32'd1);

    applyStimulus(10'h2A5, 1'b1, 0);
    applyStimulus(10'h0F3, 1'b0, 0);
    applyStimulus(10'h3FF, 1'b1, 3);

    // ack stuck high across reset release
    @(negedge Clk);
    Reset     = 1'b0;
    far_echo  = 1'b0;
    ack_level = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (SYNC) @(negedge Clk);
    send_valid = 1'b1;
    send_data  = 10'h1C7;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checkOutput("stuck_ack_ready", {31'd0, send_ready}, 32'd0);
      checkOutput("stuck_ack_no_req", {31'd0, req_out}, 32'd0);
    end
    send_valid = 1'b0;
    ack_level  = 1'b0;
    @(negedge Clk);
    checkOutput("ack_fall_ready_1cyc", {31'd0, send_ready}, 32'd0);
    @(negedge Clk);
    checkOutput("ack_fall_ready_2cyc", {31'd0, send_ready}, 32'd1);

    // reset asserted while in REQ with ack_in high
    @(negedge Clk);
    w = WIDTH'($urandom);
    send_valid = 1'b1;
    send_data  = w;
    checkOutput("pre_req_ready", {31'd0, send_ready}, 32'd1);
    @(negedge Clk);
    send_valid = 1'b0;
    ack_level  = 1'b1;
    checkOutput("in_req_req_out", {31'd0, req_out}, 32'd1);
    checkOutput("in_req_data", {22'd0, data_out}, {22'd0, w});
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_rst_req_drop", {31'd0, req_out}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_data", {22'd0, data_out}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (SYNC) @(negedge Clk);
    checkOutput("post_rst_ready_held", {31'd0, send_ready}, 32'd0);
    ack_level = 1'b0;
    @(negedge Clk);
    checkOutput("post_rst_ready_1cyc", {31'd0, send_ready}, 32'd0);
    @(negedge Clk);
    checkOutput("post_rst_ready_2cyc", {31'd0, send_ready}, 32'd1);

    // randomized transfers, mixing echo delays and silent far sides
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      applyStimulus(WIDTH'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
    end

    repeat (4) @(negedge Clk);
    checkOutput("scoreboard_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
